iob2axil_bridge: RTL

IOB2AXIL_BRIDGE -- requirements
Module: iob2axil_bridge

---
 rtl/iob2axil_bridge.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/iob2axil_bridge.sv
// IOb slave to AXI4-Lite master bridge.
// At most one transaction is in flight. Every AXI output comes from a register,
// so there is no combinational path from the IOb request inputs to the AXI side.
module iob2axil_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic                cke_i,
  // IOb slave
  input  logic                iob_avalid_i,
  input  logic [ADDR_W-1:0]   iob_addr_i,
  input  logic [DATA_W-1:0]   iob_wdata_i,
  input  logic [DATA_W/8-1:0] iob_wstrb_i,
  output logic                iob_rvalid_o,
  output logic [DATA_W-1:0]   iob_rdata_o,
  output logic                iob_ready_o,
  // AXI4-Lite master
  output logic [ADDR_W-1:0]   axil_awaddr_o,
  output logic [2:0]          axil_awprot_o,
  output logic                axil_awvalid_o,
  input  logic                axil_awready_i,
  output logic [DATA_W-1:0]   axil_wdata_o,
  output logic [DATA_W/8-1:0] axil_wstrb_o,
  output logic                axil_wvalid_o,
  input  logic                axil_wready_i,
  input  logic [1:0]          axil_bresp_i,
  input  logic                axil_bvalid_i,
  output logic                axil_bready_o,
  output logic [ADDR_W-1:0]   axil_araddr_o,
  output logic [2:0]          axil_arprot_o,
  output logic                axil_arvalid_o,
  input  logic                axil_arready_i,
  input  logic [DATA_W-1:0]   axil_rdata_i,
  input  logic [1:0]          axil_rresp_i,
  input  logic                axil_rvalid_i,
  output logic                axil_rready_o,
  output logic                err_o
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_REQ,
    S_WR_RESP,
    S_RD_REQ,
    S_RD_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_awvalid;
  logic                r_wvalid;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_rvalid;
  logic                r_err;

  logic                w_accept;
  logic                w_is_write;
  logic                w_aw_hs;
  logic                w_w_hs;
  logic                w_aw_done;
  logic                w_w_done;
  logic                w_b_hs;
  logic                w_r_hs;

  assign w_accept   = iob_avalid_i & (r_state == S_IDLE);
  assign w_is_write = |iob_wstrb_i;
  assign w_aw_hs    = r_awvalid & axil_awready_i;
  assign w_w_hs     = r_wvalid & axil_wready_i;
  // A channel is finished once its valid has dropped or is handshaking now.
  assign w_aw_done  = ~r_awvalid | axil_awready_i;
  assign w_w_done   = ~r_wvalid | axil_wready_i;
  assign w_b_hs     = (r_state == S_WR_RESP) & axil_bvalid_i;
  assign w_r_hs     = (r_state == S_RD_RESP) & axil_rvalid_i;

  // State register.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_state <= S_IDLE;
    end else if (cke_i) begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (iob_avalid_i) begin
          w_state_next = w_is_write ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_WR_REQ:  if (w_aw_done & w_w_done) w_state_next = S_WR_RESP;
      S_WR_RESP: if (axil_bvalid_i)        w_state_next = S_IDLE;
      S_RD_REQ:  if (axil_arready_i)       w_state_next = S_RD_RESP;
      S_RD_RESP: if (axil_rvalid_i)        w_state_next = S_IDLE;
      default:                             w_state_next = S_IDLE;
    endcase
  end

  // Capture the request; these registers stay frozen until the next acceptance.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (cke_i && w_accept) begin
      r_addr  <= iob_addr_i;
      r_wdata <= iob_wdata_i;
      r_wstrb <= iob_wstrb_i;
    end
  end

  // AW and W valids: raised on write acceptance, each dropped after its own handshake.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else if (cke_i) begin
      if (w_accept && w_is_write) begin
        r_awvalid <= 1'b1;
        r_wvalid  <= 1'b1;
      end else begin
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
      end
    end
  end

  // Read return path and error pulse, both one cycle after the response handshake.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
    end else if (cke_i) begin
      r_rvalid <= w_r_hs;
      r_err    <= (w_b_hs & (axil_bresp_i != 2'b00)) |
                  (w_r_hs & (axil_rresp_i != 2'b00));
      if (w_r_hs) r_rdata <= axil_rdata_i;
    end
  end

  assign iob_ready_o    = (r_state == S_IDLE);
  assign iob_rvalid_o   = r_rvalid;
  assign iob_rdata_o    = r_rdata;
  assign err_o          = r_err;

  assign axil_awaddr_o  = r_addr;
  assign axil_awprot_o  = 3'b000;
  assign axil_awvalid_o = r_awvalid;
  assign axil_wdata_o   = r_wdata;
  assign axil_wstrb_o   = r_wstrb;
  assign axil_wvalid_o  = r_wvalid;
  assign axil_bready_o  = (r_state == S_WR_RESP);
  assign axil_araddr_o  = r_addr;
  assign axil_arprot_o  = 3'b000;
  assign axil_arvalid_o = (r_state == S_RD_REQ);
  assign axil_rready_o  = (r_state == S_RD_RESP);

endmodule
